fp_result_checker: RTL and testbench
====================================

// Module: fp_result_checker
// PURPOSE
//  Self-checking scoreboard placed directly downstream of fp_unit. Stimulus logic pushes the expected
//  result, flags and opcode of every issued operation into an in-order queue. Each fp_unit ready
//  pops one entry and compares it against fp_exe_o.result/flags, then updates pass/fail counters,
//  captures the first failure and reports done/error. Handles any fp_unit latency up to DEPTH in flight.
// PARAMETERS
//  DEPTH         8   expected-queue entries (power of 2, >=2)
//  CNT_W         32  width of pass/fail counters
//  STOP_ON_FAIL  1   1: enter ERROR on first mismatch; 0: count and keep checking
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  exp_valid     in   1      push expected entry this cycle
//  exp_result    in   32     expected result
//  exp_flags     in   5      expected flags {NV,DZ,OF,UF,NX}
//  exp_opcode    in   10     opcode one-hot; bit9 fcvt_f2i, bit6 fcmp
//  exp_last      in   1      entry is the final vector
//  exp_ready     out  1      queue not full
//  dut_ready     in   1      fp_exe_o.ready
//  dut_result    in   32     fp_exe_o.result
//  dut_flags     in   5      fp_exe_o.flags
//  level         out  log2(DEPTH)+1  queue occupancy
//  pass_cnt      out  CNT_W  matched compares
//  fail_cnt      out  CNT_W  mismatched compares
//  done          out  1      sticky: last entry checked with no error
//  error         out  1      sticky: any error
//  err_code      out  2      0 none,1 mismatch,2 overflow (push while full),3 underflow (ready while empty)
//  fail_exp      out  32     expected result of first failure
//  fail_calc     out  32     calculated result of first failure
//  fail_rdiff    out  32     masked result XOR of first failure
//  fail_fdiff    out  5      flags XOR of first failure
// BEHAVIOUR
//  Reset: queue empty, level=0, exp_ready=1, counters 0, done=0, error=0, err_code=0, fail_*=0, state RUN.
//  Queue: FIFO, wrap-around pointers, level counter. Push when exp_valid & (not full or simultaneous pop).
//   Push+pop same cycle when full: both accepted, level unchanged. Push while full without pop: entry
//   dropped, error=1, err_code=2 (if err_code was 0).
//  Compare (combinational on head when dut_ready & not empty):
//   if exp_opcode[9]==0 & exp_opcode[6]==0 & dut_result==32'h7FC00000:
//     rdiff = {1'b0, dut_result[30:22]^exp_result[30:22], 22'b0}   (any quiet NaN accepted)
//   else rdiff = dut_result ^ exp_result;  fdiff = dut_flags ^ exp_flags.
//   match = (rdiff==0) & (fdiff==0).
//  Update (registered, visible cycle after dut_ready): pop head; match -> pass_cnt+1 else fail_cnt+1.
//   First mismatch loads fail_* and sets err_code=1, error=1. Counters saturate at all-ones.
//  dut_ready while empty: no pop, no count, error=1, err_code=3 (if 0).
//  States: RUN -> DONE when popped entry has exp_last=1 and error==0; RUN -> ERROR on any error if
//   STOP_ON_FAIL=1, else only on overflow/underflow. DONE and ERROR absorbing until reset; in them
//   pushes/pops ignored, counters frozen, exp_ready=0. Mismatch on last entry -> ERROR, done stays 0.
//  Reset asserted mid-run: all state returns to reset values next edge; in-flight entries discarded.
//  done and error never both 1.
// TESTING
//  1 push {3F800000,0,opc=0x002,last=0}; dut_ready 3 cycles later with 3F800000/0 -> pass_cnt=1,level=0.
//  2 opc=0x002 expect 7FC00001, dut 7FC00000 flags match -> pass (NaN mask); same with opc=0x200 -> fail, fail_rdiff=00000001.
//  3 expect flags 5'h01, dut 5'h00 -> fail_cnt=1, err_code=1, fail_fdiff=01, error=1, state ERROR.
//  4 fill DEPTH=8 entries, 9th push no pop -> err_code=2; repeat full with simultaneous push+pop -> no error, level=8.
//  5 dut_ready with empty queue after reset -> err_code=3, counters unchanged.
//  6 100 matching vectors, last has exp_last=1 -> done=1 cycle after final pop, pass_cnt=100, exp_ready=0.

Source files
------------

// File: rtl/fp_result_checker_if.sv
// rtl/fp_result_checker_if.sv - expected-entry push stream and fp_unit result bus for fp_result_checker
interface fp_result_checker_if;
   logic        exp_valid;
   logic [31:0] exp_result;
   logic [4:0]  exp_flags;
   logic [9:0]  exp_opcode;
   logic        exp_last;
   logic        exp_ready;
   logic        dut_ready;
   logic [31:0] dut_result;
   logic [4:0]  dut_flags;

   modport master (
      output exp_valid, exp_result, exp_flags, exp_opcode, exp_last,
      input  exp_ready,
      output dut_ready, dut_result, dut_flags
   );

   modport slave (
      input  exp_valid, exp_result, exp_flags, exp_opcode, exp_last,
      output exp_ready,
      input  dut_ready, dut_result, dut_flags
   );
endinterface

// File: rtl/fp_result_checker.sv
// rtl/fp_result_checker.sv - in-order scoreboard comparing fp_unit results against queued expectations
module fp_result_checker #(
   parameter int DEPTH        = 8,
   parameter int CNT_W        = 32,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset,
   fp_result_checker_if.slave     bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       pass_cnt,
   output logic [CNT_W-1:0]       fail_cnt,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             err_code,
   output logic [31:0]            fail_exp,
   output logic [31:0]            fail_calc,
   output logic [31:0]            fail_rdiff,
   output logic [4:0]             fail_fdiff
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_ERROR} state_t;
   state_t state, state_nxt;

   logic [31:0]   q_result [DEPTH];
   logic [4:0]    q_flags  [DEPTH];
   logic          q_nan_ok [DEPTH];
   logic          q_last   [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   logic        active, full, empty, push, pop, overflow, underflow;
   logic        match, mismatch;
   logic [31:0] head_result, rdiff;
   logic [4:0]  head_flags, fdiff;
   logic        head_nan_ok, head_last;
   logic        unused_opcode_bits;

   // Only fcvt_f2i and fcmp must produce the exact NaN pattern; others may return any quiet NaN.
   assign unused_opcode_bits = ^{bus.exp_opcode[8:7], bus.exp_opcode[5:0]};

   assign active    = (state == ST_RUN);
   assign full      = (level == (AW+1)'(DEPTH));
   assign empty     = (level == '0);
   assign pop       = active & bus.dut_ready & ~empty;
   assign push      = active & bus.exp_valid & (~full | pop);
   assign overflow  = active & bus.exp_valid & full & ~pop;
   assign underflow = active & bus.dut_ready & empty;
   assign bus.exp_ready = active & ~full;
   assign done      = (state == ST_DONE);

   assign head_result = q_result[rd_ptr];
   assign head_flags  = q_flags[rd_ptr];
   assign head_nan_ok = q_nan_ok[rd_ptr];
   assign head_last   = q_last[rd_ptr];

   always_comb begin
      rdiff = bus.dut_result ^ head_result;
      if (head_nan_ok && bus.dut_result == 32'h7FC0_0000)
         rdiff = {1'b0, bus.dut_result[30:22] ^ head_result[30:22], 22'b0};
      fdiff    = bus.dut_flags ^ head_flags;
      match    = (rdiff == '0) && (fdiff == '0);
      mismatch = pop & ~match;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // A run that ends on its last entry with any error recorded finishes in ERROR, never DONE.
   always_comb begin
      state_nxt = state;
      if (state == ST_RUN) begin
         if (overflow || underflow || (mismatch && STOP_ON_FAIL))
            state_nxt = ST_ERROR;
         else if (pop && head_last)
            state_nxt = (error || mismatch) ? ST_ERROR : ST_DONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_result[wr_ptr] <= bus.exp_result;
         q_flags[wr_ptr]  <= bus.exp_flags;
         q_nan_ok[wr_ptr] <= ~bus.exp_opcode[9] & ~bus.exp_opcode[6];
         q_last[wr_ptr]   <= bus.exp_last;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         error      <= 1'b0;
         err_code   <= 2'd0;
         fail_exp   <= '0;
         fail_calc  <= '0;
         fail_rdiff <= '0;
         fail_fdiff <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;

         if (pop && match && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
         if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            // fail_cnt saturates, so zero identifies the first mismatch exactly.
            if (fail_cnt == '0) begin
               fail_exp   <= head_result;
               fail_calc  <= bus.dut_result;
               fail_rdiff <= rdiff;
               fail_fdiff <= fdiff;
            end
         end

         if (overflow || underflow || mismatch) begin
            error <= 1'b1;
            if (err_code == 2'd0)
               err_code <= overflow ? 2'd2 : underflow ? 2'd3 : 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_fp_result_checker.sv
// tb/tb_fp_result_checker.sv - directed self-checking bench for fp_result_checker
module tb_fp_result_checker;
   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  level;
   logic [31:0] pass_cnt, fail_cnt;
   logic        done, error;
   logic [1:0]  err_code;
   logic [31:0] fail_exp, fail_calc, fail_rdiff;
   logic [4:0]  fail_fdiff;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clock = ~clock;

   fp_result_checker_if bus ();

   fp_result_checker dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .level      (level),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .done       (done),
      .error      (error),
      .err_code   (err_code),
      .fail_exp   (fail_exp),
      .fail_calc  (fail_calc),
      .fail_rdiff (fail_rdiff),
      .fail_fdiff (fail_fdiff)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.exp_valid = 1'b0; bus.exp_result = '0; bus.exp_flags = '0;
      bus.exp_opcode = '0; bus.exp_last = 1'b0;
      bus.dut_ready = 1'b0; bus.dut_result = '0; bus.dut_flags = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_push(input logic [31:0] r, input logic [4:0] f, input logic [9:0] o, input logic l);
      bus.exp_valid = 1'b1; bus.exp_result = r; bus.exp_flags = f;
      bus.exp_opcode = o; bus.exp_last = l;
   endtask

   task automatic set_ready(input logic [31:0] r, input logic [4:0] f);
      bus.dut_ready = 1'b1; bus.dut_result = r; bus.dut_flags = f;
   endtask

   task automatic step_idle();
      tick();
      bus.exp_valid = 1'b0;
      bus.dut_ready = 1'b0;
   endtask

   task automatic push(input logic [31:0] r, input logic [4:0] f, input logic [9:0] o, input logic l);
      set_push(r, f, o, l);
      step_idle();
   endtask

   task automatic ready(input logic [31:0] r, input logic [4:0] f);
      set_ready(r, f);
      step_idle();
   endtask

   initial begin
      // Reset values
      do_reset();
      check("rst_level", level, 0);
      check("rst_exp_ready", bus.exp_ready, 1);
      check("rst_pass", pass_cnt, 0);
      check("rst_fail", fail_cnt, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_fail_exp", fail_exp, 0);

      // Basic match with three-cycle latency
      push(32'h3F80_0000, 5'h00, 10'h002, 1'b0);
      check("t1_level_push", level, 1);
      tick();
      tick();
      ready(32'h3F80_0000, 5'h00);
      check("t1_pass", pass_cnt, 1);
      check("t1_level", level, 0);
      check("t1_error", error, 0);

      // Quiet-NaN tolerance, then exact-NaN opcode mismatch
      push(32'h7FC0_0001, 5'h10, 10'h002, 1'b0);
      ready(32'h7FC0_0000, 5'h10);
      check("t2_nan_pass", pass_cnt, 2);
      check("t2_nan_fail_cnt", fail_cnt, 0);
      push(32'h7FC0_0001, 5'h10, 10'h200, 1'b0);
      ready(32'h7FC0_0000, 5'h10);
      check("t2_f2i_fail_cnt", fail_cnt, 1);
      check("t2_rdiff", fail_rdiff, 32'h0000_0001);
      check("t2_fail_exp", fail_exp, 32'h7FC0_0001);
      check("t2_fail_calc", fail_calc, 32'h7FC0_0000);
      check("t2_err_code", err_code, 1);
      check("t2_error", error, 1);
      check("t2_exp_ready_err", bus.exp_ready, 0);
      push(32'h1234_5678, 5'h00, 10'h002, 1'b0);
      check("t2_push_ignored", level, 0);
      ready(32'h1234_5678, 5'h00);
      check("t2_pass_frozen", pass_cnt, 2);

      // Flags-only mismatch
      do_reset();
      push(32'h3F80_0000, 5'h01, 10'h002, 1'b0);
      ready(32'h3F80_0000, 5'h00);
      check("t3_fail_cnt", fail_cnt, 1);
      check("t3_err_code", err_code, 1);
      check("t3_fdiff", fail_fdiff, 5'h01);
      check("t3_rdiff", fail_rdiff, 0);
      check("t3_error", error, 1);
      check("t3_done", done, 0);

      // Overflow when full
      do_reset();
      for (int i = 0; i < 8; i++) push(32'h1000 + i, 5'h00, 10'h002, 1'b0);
      check("t4_level_full", level, 8);
      check("t4_exp_ready_full", bus.exp_ready, 0);
      push(32'h1008, 5'h00, 10'h002, 1'b0);
      check("t4_ovf_code", err_code, 2);
      check("t4_ovf_error", error, 1);
      check("t4_ovf_level", level, 8);

      // Reset with entries in flight, then full push+pop
      do_reset();
      check("t4_rst_level", level, 0);
      check("t4_rst_error", error, 0);
      for (int i = 0; i < 8; i++) push(32'h1000 + i, 5'h00, 10'h002, 1'b0);
      for (int k = 0; k < 3; k++) begin
         set_push(32'h2000 + k, 5'h00, 10'h002, 1'b0);
         set_ready(32'h1000 + k, 5'h00);
         step_idle();
      end
      check("t4_pp_level", level, 8);
      check("t4_pp_error", error, 0);
      check("t4_pp_code", err_code, 0);
      check("t4_pp_pass", pass_cnt, 3);
      ready(32'h1003, 5'h00);
      check("t4_pop_level", level, 7);
      check("t4_pop_pass", pass_cnt, 4);
      check("t4_pop_exp_ready", bus.exp_ready, 1);

      // Underflow
      do_reset();
      ready(32'h0, 5'h00);
      check("t5_code", err_code, 3);
      check("t5_error", error, 1);
      check("t5_pass", pass_cnt, 0);
      check("t5_fail", fail_cnt, 0);

      // 100-vector run ending in done
      do_reset();
      for (int i = 0; i < 100; i++) begin
         push(32'h4000_0000 + i, 5'(i), 10'h001 << (i % 10), i == 99);
         if (i == 99) check("t6_done_before", done, 0);
         ready(32'h4000_0000 + i, 5'(i));
      end
      check("t6_done", done, 1);
      check("t6_pass", pass_cnt, 100);
      check("t6_fail", fail_cnt, 0);
      check("t6_error", error, 0);
      check("t6_exp_ready", bus.exp_ready, 0);
      check("t6_level", level, 0);
      ready(32'h0, 5'h00);
      check("t6_done_sticky", done, 1);
      check("t6_no_underflow", error, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
